// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage: 16-entry register file, instruction decode, and a
// single-slot valid/ready pipeline register feeding the ALU.
// Optional macro ALU_FETCH_WB_BYPASS_EN: same-cycle writeback-to-read bypass.

module alu_operand_fetch_reg #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (we) val_d = wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) val_q <= '0;
    else          val_q <= val_d;
  end

  assign q = val_q;
endmodule

module alu_operand_fetch #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        op,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] Imm,
  output logic [3:0]        rd
);
  logic [NREGS-1:0][DATA_W-1:0] regs;
  logic [NREGS-1:1]             we_vec;

  logic [AW-1:0]     rs_addr, rt_addr;
  logic [DATA_W-1:0] rd_a, rd_b;

  logic              out_valid_q, out_valid_d;
  logic [3:0]        op_q, op_d, rd_q, rd_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic              accept;

  // Register 0 is a constant zero, so it needs no storage and swallows writes.
  assign regs[0] = '0;

  always_comb begin
    we_vec = '0;
    for (int i = 1; i < NREGS; i++)
      we_vec[i] = wb_en && (wb_addr == AW'(i));
  end

  for (genvar i = 1; i < NREGS; i++) begin : g_reg
    alu_operand_fetch_reg #(.DATA_W(DATA_W)) u_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (we_vec[i]),
      .wdata   (wb_data),
      .q       (regs[i])
    );
  end

  assign rs_addr = instr[7:4];
  assign rt_addr = instr[3:0];

  always_comb begin
    rd_a = regs[rs_addr];
    rd_b = regs[rt_addr];
`ifdef ALU_FETCH_WB_BYPASS_EN
    // Write-through: a dependent instruction right behind the writer sees the new value.
    if (wb_en && wb_addr == rs_addr && rs_addr != '0) rd_a = wb_data;
    if (wb_en && wb_addr == rt_addr && rt_addr != '0) rd_b = wb_data;
`endif
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    op_d        = op_q;
    rd_d        = rd_q;
    a_d         = a_q;
    b_d         = b_q;
    imm_d       = imm_q;
    if (accept) begin
      out_valid_d = 1'b1;
      op_d        = instr[15:12];
      rd_d        = instr[11:8];
      a_d         = rd_a;
      b_d         = rd_b;
      imm_d       = {{(DATA_W-4){instr[3]}}, instr[3:0]};
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      op_q        <= '0;
      rd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
    end
  end

  assign out_valid = out_valid_q;
  assign op        = op_q;
  assign rd        = rd_q;
  assign A         = a_q;
  assign B         = b_q;
  assign Imm       = imm_q;
endmodule

// File: tb/tb_alu_operand_fetch.sv
// Directed bench for alu_operand_fetch: register-file model plus a scoreboard
// queue of expected slot contents, popped on each output transfer.

module tb_alu_operand_fetch;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  op;
  logic [15:0] A, B, Imm;
  logic [3:0]  rd;

  alu_operand_fetch #(.DATA_W(16), .NREGS(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .op(op), .A(A), .B(B),
    .Imm(Imm), .rd(rd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
  } slot_t;

  slot_t       sb[$];
  logic [15:0] mreg[16];
  int          checks = 0;
  int          errors = 0;

`ifdef ALU_FETCH_WB_BYPASS_EN
  localparam logic [15:0] BYP_EXP = 16'h1234;
`else
  localparam logic [15:0] BYP_EXP = 16'h0007;
`endif

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rdp(input logic [3:0] x);
    if (x == 4'd0) return 16'h0;
`ifdef ALU_FETCH_WB_BYPASS_EN
    if (wb_en && wb_addr == x) return wb_data;
`endif
    return mreg[x];
  endfunction

  // Called just after a rising edge; drives inputs, checks at the falling edge,
  // advances the model, and returns just after the next rising edge.
  task automatic step(input logic iv, input logic [15:0] ins, input logic we,
                      input logic [3:0] wa, input logic [15:0] wd, input logic ordy);
    logic  exp_ready;
    slot_t s;
    in_valid = iv; instr = ins; wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
    @(negedge clk);
    exp_ready = (sb.size() == 0) || ordy;
    chk("in_ready", {15'b0, in_ready}, {15'b0, exp_ready});
    chk("out_valid", {15'b0, out_valid}, {15'b0, sb.size() != 0});
    if (sb.size() != 0) begin
      chk("op", {12'b0, op}, {12'b0, sb[0].op});
      chk("rd", {12'b0, rd}, {12'b0, sb[0].rd});
      chk("A", A, sb[0].a);
      chk("B", B, sb[0].b);
      chk("Imm", Imm, sb[0].imm);
      if (ordy) void'(sb.pop_front());
    end
    if (iv && exp_ready) begin
      s.op  = ins[15:12];
      s.rd  = ins[11:8];
      s.a   = rdp(ins[7:4]);
      s.b   = rdp(ins[3:0]);
      s.imm = {{12{ins[3]}}, ins[3:0]};
      sb.push_back(s);
    end
    if (we && wa != 4'd0) mreg[wa] = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    chk("rst_out_valid", {15'b0, out_valid}, 16'h0);
    chk("rst_op", {12'b0, op}, 16'h0);
    chk("rst_rd", {12'b0, rd}, 16'h0);
    chk("rst_A", A, 16'h0);
    chk("rst_B", B, 16'h0);
    chk("rst_Imm", Imm, 16'h0);
    sb.delete();
    foreach (mreg[i]) mreg[i] = 16'h0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 0; instr = 0; wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 0;
    foreach (mreg[i]) mreg[i] = 16'h0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Preload registers and leave a valid slot, then reset over it
    step(0, 16'h0, 1, 4'd3, 16'h0011, 1);
    step(1, 16'h9A35, 1, 4'd5, 16'h0022, 1);
    step(0, 16'h0, 0, 4'd0, 16'h0, 0);
    do_reset();
    step(1, 16'h0035, 0, 4'd0, 16'h0, 1);
    step(0, 16'h0, 0, 4'd0, 16'h0, 1);

    // Basic fetch: reg3=12, reg5=0x00FF, instr 0x7135
    step(0, 16'h0, 1, 4'd3, 16'd12, 1);
    step(0, 16'h0, 1, 4'd5, 16'h00FF, 1);
    step(1, 16'h7135, 0, 4'd0, 16'h0, 1);
    chk("fetch_A_direct", A, 16'd12);
    chk("fetch_Imm_direct", Imm, 16'h0005);
    step(0, 16'h0, 0, 4'd0, 16'h0, 1);

    // Negative imm4, and register 0 ignores writes
    step(1, 16'h250C, 0, 4'd0, 16'h0, 1);
    chk("imm_neg_direct", Imm, 16'hFFFC);
    step(0, 16'h0, 1, 4'd0, 16'hBEEF, 1);
    step(1, 16'h3000, 0, 4'd0, 16'h0, 1);
    chk("r0_A_direct", A, 16'h0);
    step(0, 16'h0, 0, 4'd0, 16'h0, 1);

    // Stall 4 cycles with a pending instr and a write to the latched rs
    step(1, 16'h4635, 0, 4'd0, 16'h0, 1);
    for (int i = 0; i < 4; i++) step(1, 16'h5753, 1, 4'd3, 16'h0AA0 + 16'(i), 0);
    step(1, 16'h5753, 0, 4'd0, 16'h0, 1);
    step(0, 16'h0, 0, 4'd0, 16'h0, 1);

    // Back-to-back stream, rs=rt case included
    step(1, 16'h1133, 0, 4'd0, 16'h0, 1);
    step(1, 16'h2253, 0, 4'd0, 16'h0, 1);
    step(1, 16'h3355, 0, 4'd0, 16'h0, 1);
    step(0, 16'h0, 0, 4'd0, 16'h0, 1);

    // Same-cycle writeback vs read of reg4
    step(0, 16'h0, 1, 4'd4, 16'h0007, 1);
    step(1, 16'h1840, 1, 4'd4, 16'h1234, 1);
    chk("bypass_A_direct", A, BYP_EXP);
    step(0, 16'h0, 0, 4'd0, 16'h0, 1);

    // Reset asserted mid-stall drops out_valid asynchronously
    step(1, 16'h6144, 0, 4'd0, 16'h0, 1);
    step(0, 16'h0, 0, 4'd0, 16'h0, 0);
    chk("stall_valid_before_rst", {15'b0, out_valid}, 16'h1);
    do_reset();
    step(1, 16'h7144, 0, 4'd0, 16'h0, 1);
    step(0, 16'h0, 0, 4'd0, 16'h0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
